mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-low reset.
REQ-002 Parameter RD_LAT, default 1: cycles from the r_en cycle to valid ans1; legal range 1..4.
REQ-003 Port clk  input  1  rising-edge clock.
REQ-004 Port rst  input  1  asynchronous active-low reset; 0 clears all state.
REQ-005 Port req_valid  input  1  core request present.
REQ-006 Port req_ready  output  1  block can accept a request.
REQ-007 Port req_we  input  1  1 = store, 0 = load.
REQ-008 Port req_size  input  2  00 byte, 01 halfword, 10 word; 11 is treated as word.
REQ-009 Port req_signed  input  1  sign-extend sub-word loads.
REQ-010 Port req_addr  input  32  byte address.
REQ-011 Port req_wdata  input  32  store data, right-aligned.
REQ-012 Port resp_valid  output  1  one-cycle completion pulse.
REQ-013 Port resp_rdata  output  32  load result; 0 for stores and errors.
REQ-014 Port resp_err  output  1  misaligned access; valid with resp_valid.
REQ-015 Port w_en  output  1  data memory write strobe.
REQ-016 Port r_en  output  1  data memory read strobe.
REQ-017 Port adr  output  32  word index: {2'b00, req_addr[31:2]}.
REQ-018 Port instr  output  32  data memory write data.
REQ-019 Port ans1  input  32  data memory read data.

Function
REQ-020 The FSM SHALL have the states IDLE, RD, RWAIT, MERGE, WR and RESP.
REQ-021 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted on req_valid&&req_ready, latching we, size, signed, addr and wdata.
REQ-022 While busy (not IDLE), req_valid SHALL be ignored and no input SHALL be re-sampled.
REQ-023 A halfword access with addr[0]=1, or a word access with addr[1:0]!=0, is misaligned:
- IDLE->RESP with no w_en or r_en.
- resp_err=1, resp_rdata=0.
REQ-024 Load: IDLE->RD:
- RD drives r_en=1 for exactly one cycle.
- RWAIT counts RD_LAT cycles and captures ans1 on the last of them.
- Then RESP.
REQ-025 Load extraction:
- byte lane = addr[1:0]; halfword lane = addr[1].
- Sign-extend when req_signed=1, otherwise zero-extend.
- A word load is returned unmodified.
REQ-026 Word store: IDLE->WR:
- WR drives w_en=1 for one cycle with instr=wdata.
- Then RESP.
REQ-027 Sub-word store (read-modify-write):
- RD/RWAIT as for a load.
- MERGE replaces the addressed byte or halfword of the captured word with wdata[7:0] or wdata[15:0].
- WR writes the merged word.
- Then RESP.
REQ-028 adr SHALL stay constant from RD or WR entry until RESP.
REQ-029 r_en and w_en SHALL never be 1 in the same cycle and SHALL be 0 outside RD and WR respectively.
REQ-030 RESP SHALL last one cycle and assert resp_valid=1; the next state is IDLE, with no backpressure.
REQ-031 resp_rdata and resp_err SHALL be valid only while resp_valid=1; they are held at 0 otherwise.
REQ-032 Latency, with acceptance at edge T (cycles counted from T):
- Misaligned: resp_valid in cycle 1.
- Word store: w_en in cycle 1, resp in cycle 2.
- Load: r_en in cycle 1, resp in cycle 2+RD_LAT.
- Sub-word store: resp in cycle 4+RD_LAT.
REQ-033 Back-to-back: a new request SHALL be accepted on the first edge after the RESP cycle.

Reset
REQ-034 rst=0 SHALL immediately force:
- state IDLE.
- w_en, r_en, resp_valid, resp_err = 0.
- adr, instr, resp_rdata = 0.
- req_ready = 0 while rst=0.
REQ-035 Reset asserted mid-operation SHALL abandon the access: no w_en after reset and no resp_valid for the abandoned request.
REQ-036 After rst rises, req_ready SHALL be 1 from the first clock edge.

Verification
REQ-037 Word store, addr=0x0000_0010, wdata=0xF0F0_F0F0 -> w_en for one cycle with adr=0x4 and instr=0xF0F0_F0F0, then resp_valid with err=0.
REQ-038 Signed byte load, addr=0x13, memory word=0x80AA_BBCC, RD_LAT=1 -> r_en with adr=0x4, resp_rdata=0xFFFF_FF80 in cycle 3.
REQ-039 Halfword store, addr=0x12, wdata=0x1234, memory word=0xAAAA_BBBB -> single read, then w_en with instr=0x1234_BBBB.
REQ-040 Word load at addr=0x6 -> resp_err=1 and resp_rdata=0 in cycle 1, with no r_en or w_en.
REQ-041 rst pulled low during RWAIT of a sub-word store -> no w_en, no resp_valid, req_ready=1 after release.
REQ-042 Run with RD_LAT=3 and two back-to-back word loads -> each resp_valid arrives 5 cycles after acceptance, and r_en/w_en are never high together.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Load/store controller between a core request port and a single-ported data memory.
// Sub-word stores are done as read-modify-write; misaligned accesses return an error.
module mem_access_ctrl #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        w_en,
    output logic        r_en,
    output logic [31:0] adr,
    output logic [31:0] instr,
    input  logic [31:0] ans1
);

    typedef enum logic [2:0] {IDLE, RD, RWAIT, MERGE, WR, RESP} state_t;

    state_t      state, state_nx;
    logic        we_q, sgn_q, err_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [15:0] wdata_q;
    logic [31:0] word_q;
    logic [31:0] wr_q;
    logic [1:0]  cnt;
    logic        accept, misal;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_val, merged;

    assign accept = (state == IDLE) && req_valid;
    assign misal  = ((req_size == 2'b01) && req_addr[0]) ||
                    (req_size[1] && (req_addr[1:0] != 2'b00));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (misal)                    state_nx = RESP;
                    else if (req_we && req_size[1]) state_nx = WR;
                    else                          state_nx = RD;
                end
            end
            RD:      state_nx = RWAIT;
            RWAIT:   if (cnt == 2'd0) state_nx = we_q ? MERGE : RESP;
            MERGE:   state_nx = WR;
            WR:      state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= 1'b0;
            sgn_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            wr_q    <= '0;
            cnt     <= '0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                sgn_q   <= req_signed;
                err_q   <= misal;
                size_q  <= req_size;
                addr_q  <= req_addr;
                wdata_q <= req_wdata[15:0];
                wr_q    <= req_wdata;
            end
            if (state == RD) cnt <= 2'(RD_LAT - 1);
            // Memory data is only valid on the last wait cycle.
            if (state == RWAIT) begin
                if (cnt == 2'd0) word_q <= ans1;
                else             cnt    <= cnt - 2'd1;
            end
            if (state == MERGE) wr_q <= merged;
        end
    end

    always_comb begin
        lane_b   = word_q[{addr_q[1:0], 3'b000} +: 8];
        lane_h   = word_q[{addr_q[1], 4'b0000} +: 16];
        load_val = word_q;
        merged   = word_q;
        case (size_q)
            2'b00: begin
                load_val = {{24{sgn_q & lane_b[7]}}, lane_b};
                merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            end
            2'b01: begin
                load_val = {{16{sgn_q & lane_h[15]}}, lane_h};
                merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
            end
            default: begin
                load_val = word_q;
                merged   = word_q;
            end
        endcase
    end

    assign req_ready  = (state == IDLE) && rst;
    assign r_en       = (state == RD);
    assign w_en       = (state == WR);
    assign resp_valid = (state == RESP);
    assign resp_err   = resp_valid && err_q;
    assign resp_rdata = (resp_valid && !err_q && !we_q) ? load_val : '0;
    assign adr        = {2'b00, addr_q[31:2]};
    assign instr      = wr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl: a behavioural memory model predicts each
// response, its latency, the memory strobes and the resulting memory contents.
module tb_mem_access_ctrl;

    localparam int unsigned L = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0, req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = '0;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        resp_valid, resp_err, w_en, r_en;
    logic [31:0] resp_rdata, adr, instr, ans1;

    always #5 clk = ~clk;

    mem_access_ctrl #(.RD_LAT(L)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .w_en(w_en), .r_en(r_en), .adr(adr), .instr(instr), .ans1(ans1)
    );

    // Environment memory: 16 words (aliased), read data appears L cycles after r_en.
    logic [31:0] mem [16];
    logic [31:0] pipe [L];
    logic        mem_clr = 1'b1;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (w_en) begin
            mem[adr[3:0]] <= instr;
        end
        pipe[0] <= r_en ? mem[adr[3:0]] : 32'hDEAD_BEEF;
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign ans1 = pipe[L-1];

    logic [31:0] ref_mem [16];
    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] last_rdata, last_instr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz,
                                               input logic s, input logic [31:0] a);
        logic [31:0] v;
        int unsigned sh;
        if (sz == 2'd0) begin
            sh = (a % 4) * 8;
            v  = (w >> sh) % 256;
            if (s && v >= 128) v = v - 256;
        end else if (sz == 2'd1) begin
            sh = ((a % 4) / 2) * 16;
            v  = (w >> sh) % 65536;
            if (s && v >= 32768) v = v - 65536;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_merge(input logic [31:0] w, input logic [1:0] sz,
                                                input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] mask;
        int unsigned sh;
        if (sz == 2'd0) begin
            sh = (a % 4) * 8;
            mask = 32'd255 << sh;
            return (w & ~mask) | ((wd % 256) << sh);
        end
        sh = ((a % 4) / 2) * 16;
        mask = 32'd65535 << sh;
        return (w & ~mask) | ((wd % 65536) << sh);
    endfunction

    task automatic run_txn(input logic we, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd, input bit b2b);
        int unsigned idx;
        logic        e_err;
        int          e_lat, e_rd, e_wr, e_wr_cyc;
        logic [31:0] e_rdata, e_instr, old;
        int          waits, got_lat, n_rd, n_wr, rd_cyc, wr_cyc, both, leak, adr_chg;
        logic [31:0] rd_adr, wr_adr, wr_data, base, g_rdata;
        logic        g_err, adr_seen;

        idx   = (a / 4) % 16;
        old   = ref_mem[idx];
        e_err = (sz == 2'd1 && a % 2 != 0) || (sz >= 2'd2 && a % 4 != 0);
        e_rd = 0; e_wr = 0; e_wr_cyc = 0; e_rdata = 0; e_instr = 0;
        if (e_err) begin
            e_lat = 1;
        end else if (!we) begin
            e_lat = 2 + L; e_rd = 1;
            e_rdata = model_load(old, sz, sg, a);
        end else if (sz >= 2'd2) begin
            e_lat = 2; e_wr = 1; e_wr_cyc = 1; e_instr = wd;
            ref_mem[idx] = wd;
        end else begin
            e_lat = 4 + L; e_rd = 1; e_wr = 1; e_wr_cyc = 3 + L;
            e_instr = model_merge(old, sz, a, wd);
            ref_mem[idx] = e_instr;
        end

        req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        waits = 0;
        while (!req_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        if (b2b) check("b2b_wait", 32'(waits), 32'd1);
        else if (waits >= 20) check("ready_timeout", 32'(waits), 32'd0);
        @(posedge clk);
        #1;
        req_valid = 1'($urandom); req_we = 1'($urandom); req_size = 2'($urandom);
        req_addr = $urandom; req_wdata = $urandom; req_signed = 1'($urandom);

        got_lat = 0; n_rd = 0; n_wr = 0; rd_cyc = 0; wr_cyc = 0; both = 0; leak = 0;
        adr_chg = 0; adr_seen = 1'b0; base = '0; rd_adr = '0; wr_adr = '0; wr_data = '0;
        g_rdata = '0; g_err = 1'b0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            if (r_en) begin n_rd++; rd_cyc = cyc; rd_adr = adr; end
            if (w_en) begin n_wr++; wr_cyc = cyc; wr_adr = adr; wr_data = instr; end
            if (r_en && w_en) both++;
            if (!resp_valid && (resp_rdata != 0 || resp_err)) leak++;
            if ((r_en || w_en) && !adr_seen) begin adr_seen = 1'b1; base = adr; end
            if (adr_seen && adr != base) adr_chg++;
            if (resp_valid) begin
                got_lat = cyc; g_rdata = resp_rdata; g_err = resp_err;
                break;
            end
            req_valid = 1'($urandom); req_we = 1'($urandom); req_size = 2'($urandom);
            req_addr = $urandom; req_wdata = $urandom;
        end
        req_valid = 1'b0;

        check("latency", 32'(got_lat), 32'(e_lat));
        check("resp_err", {31'd0, g_err}, {31'd0, e_err});
        check("resp_rdata", g_rdata, e_rdata);
        check("n_reads", 32'(n_rd), 32'(e_rd));
        check("n_writes", 32'(n_wr), 32'(e_wr));
        check("rw_overlap", 32'(both), 32'd0);
        check("idle_outputs", 32'(leak), 32'd0);
        check("adr_stable", 32'(adr_chg), 32'd0);
        if (e_rd == 1) begin
            check("rd_cycle", 32'(rd_cyc), 32'd1);
            check("rd_adr", rd_adr, a >> 2);
        end
        if (e_wr == 1) begin
            check("wr_cycle", 32'(wr_cyc), 32'(e_wr_cyc));
            check("wr_adr", wr_adr, a >> 2);
            check("wr_data", wr_data, e_instr);
        end
        check("mem_word", mem[idx], ref_mem[idx]);
        last_rdata = g_rdata;
        last_instr = wr_data;
    endtask

    task automatic reset_mid_rmw(input logic [31:0] a);
        int unsigned idx;
        int bad_wr, bad_resp;
        idx = (a / 4) % 16;
        req_we = 1'b1; req_size = 2'b01; req_signed = 1'b0;
        req_addr = a; req_wdata = $urandom; req_valid = 1'b1;
        while (!req_ready) @(negedge clk);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_en", {30'd0, r_en, w_en}, 32'd0);
        check("rst_resp", {31'd0, resp_valid}, 32'd0);
        check("rst_adr", adr, 32'd0);
        check("rst_instr", instr, 32'd0);
        bad_wr = 0; bad_resp = 0;
        repeat (3) begin
            @(negedge clk);
            if (w_en) bad_wr++;
            if (resp_valid) bad_resp++;
        end
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_rst", {31'd0, req_ready}, 32'd1);
        repeat (10) begin
            if (w_en) bad_wr++;
            if (resp_valid) bad_resp++;
            @(negedge clk);
        end
        check("abandon_wr", 32'(bad_wr), 32'd0);
        check("abandon_resp", 32'(bad_resp), 32'd0);
        check("abandon_mem", mem[idx], ref_mem[idx]);
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        repeat (2) @(negedge clk);
        check("init_ready", {31'd0, req_ready}, 32'd0);
        check("init_en", {30'd0, r_en, w_en}, 32'd0);
        check("init_resp", {30'd0, resp_valid, resp_err}, 32'd0);
        check("init_adr", adr, 32'd0);
        check("init_instr", instr, 32'd0);
        check("init_rdata", resp_rdata, 32'd0);
        mem_clr = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_init", {31'd0, req_ready}, 32'd1);

        run_txn(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hF0F0_F0F0, 1'b0);
        run_txn(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h80AA_BBCC, 1'b0);
        run_txn(1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0, 1'b0);
        check("signed_byte_const", last_rdata, 32'hFFFF_FF80);
        run_txn(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hAAAA_BBBB, 1'b0);
        run_txn(1'b1, 2'b01, 1'b0, 32'h0000_0012, 32'h0000_1234, 1'b0);
        check("hw_merge_const", last_instr, 32'h1234_BBBB);
        run_txn(1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0, 1'b0);
        reset_mid_rmw(32'h0000_0022);
        run_txn(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
        run_txn(1'b0, 2'b11, 1'b0, 32'h0000_0014, 32'h0, 1'b1);

        for (int n = 0; n < 80; n++) begin
            a  = $urandom;
            sz = 2'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b01) a[0] = 1'b0;
                else if (sz[1]) a[1:0] = 2'b00;
            end
            if ($urandom_range(0, 1) == 0) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                run_txn(1'($urandom), sz, 1'($urandom), a, $urandom, 1'b0);
            end else begin
                run_txn(1'($urandom), sz, 1'($urandom), a, $urandom, 1'b1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
